// File: rtl/ula_nibble_sequencer.sv
// Runs W-bit operations on a 4-bit combinational ULA, one nibble per clock, LSB first,
// chaining carry through a registered flop and assembling the wide result.
module ula_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic                   carry_in,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out,
  output logic                   zero,
  output logic [3:0]             ula_a,
  output logic [3:0]             ula_b,
  output logic [2:0]             ula_sel,
  output logic                   ula_cin,
  input  logic [3:0]             ula_res,
  input  logic                   ula_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  result_q, result_d;
  logic          carry_out_q, carry_out_d;
  logic          zero_q, zero_d;

  logic [3:0]    nib_a, nib_b;
  logic          arith;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;

    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (k_q == KW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
    arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    // SUB is fed to the ULA as an ADD of the inverted B nibble; the carry flop supplies the +1.
    ula_a   = '0;
    ula_b   = '0;
    ula_sel = '0;
    ula_cin = 1'b0;
    if (state_q == S_RUN) begin
      ula_a   = nib_a;
      ula_b   = (op_q == OP_SUB) ? ~nib_b : nib_b;
      ula_sel = (op_q == OP_SUB) ? OP_ADD : op_q;
      ula_cin = carry_q;
    end

    case (state_q)
      S_RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (k_q == KW'(i)) result_d[4*i +: 4] = (op_q[2:1] == 2'b11) ? 4'h0 : ula_res;
        end
        carry_d = arith & ula_cout;
        k_d     = k_q + KW'(1);
        if (k_q == KW'(NIBBLES - 1)) begin
          state_d     = S_DONE;
          k_d         = '0;
          carry_out_d = arith & ula_cout;
          zero_d      = (result_d == '0);
        end
      end
      default: begin
        // IDLE and DONE both accept; flags from the last op hold until a new accept.
        state_d = S_IDLE;
        if (start) begin
          state_d     = S_RUN;
          k_d         = '0;
          op_d        = op;
          a_d         = op_a;
          b_d         = op_b;
          result_d    = '0;
          carry_out_d = 1'b0;
          zero_d      = 1'b0;
          carry_d     = (op == OP_ADD) ? carry_in : (op == OP_SUB);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign zero      = zero_q;

endmodule

// File: doc/ula_nibble_sequencer.md
Name: ula_nibble_sequencer

Overview:
- Controller that runs multi-nibble operations on the team's 4-bit combinational ULA.
- Captures wide operands on a start handshake and feeds the ULA one nibble per clock, LSB nibble first.
- Chains carry between nibbles in a registered carry flop and assembles the wide result.
- Sits between a requesting unit (CPU-style datapath / testbench master) and a single ULA instance.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation (W = 4*NIBBLES, default 16-bit); legal range 1..8

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
op  input  3  000 AND, 001 OR, 010 NOT A, 011 NAND, 100 ADD, 101 SUB, 110/111 zero
carry_in  input  1  initial carry for ADD; ignored for all other ops
op_a  input  W  operand A, captured on accepted start
op_b  input  W  operand B, captured on accepted start
busy  output  1  high while nibbles are being processed
done  output  1  one-cycle pulse, result valid
result  output  W  assembled result, held until next accepted start
carry_out  output  1  ADD: final carry; SUB: 1 = no borrow (A>=B unsigned); logic ops: 0
zero  output  1  result == 0, valid with done and held
ula_a  output  4  nibble of captured A to ULA
ula_b  output  4  nibble of captured B (inverted for SUB) to ULA
ula_sel  output  3  ULA selector
ula_cin  output  1  ULA carry_in
ula_res  input  4  ULA resultado, combinational from ula_* outputs
ula_cout  input  1  ULA carry_out, combinational

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- States:
  - IDLE: default.
  - RUN: nibble index k = 0..NIBBLES-1.
  - DONE: lasts exactly one cycle.
- Reset (async, any state, including mid-RUN):
  - State goes to IDLE, k=0, carry flop 0.
  - busy=0, done=0, result=0, carry_out=0, zero=0.
  - ula_a/ula_b/ula_sel/ula_cin all 0.
  - An aborted operation never produces done.
- Accept: on the rising edge with start=1 in IDLE or DONE.
  - Capture op, op_a, op_b.
  - Clear result to 0.
  - Load carry flop: ADD -> carry_in; SUB -> 1; others -> 0.
  - Set k=0 and go to RUN.
  - start in RUN is ignored (no queueing, no effect on the current operation).
- RUN, per cycle, combinational drive:
  - ula_a = A[4k+3:4k].
  - ula_b = B nibble for all ops except SUB, where ula_b = ~B nibble.
  - ula_sel = 100 for SUB, else the captured op.
  - ula_cin = carry flop.
- RUN, per cycle, on the rising edge:
  - result[4k+3:4k] <= ula_res; ops 110/111 write 0000 regardless of ula_res.
  - carry flop <= ula_cout for ADD/SUB, else 0.
  - k increments; at k = NIBBLES-1 the next state is DONE.
- Outside RUN, ula_* outputs are driven 0.
- busy: 1 exactly in RUN.
- Latency: start accepted at edge t; busy=1 in cycles t+1..t+NIBBLES; done=1 in cycle t+NIBBLES+1.
- DONE:
  - done=1; carry_out = carry flop (ADD/SUB), 0 otherwise; zero = (result==0).
  - Returns to IDLE unless start=1, in which case a new op is accepted (back-to-back, no bubble).
  - carry_out and zero hold their values until the next accept, then clear to 0.
- Width rules:
  - Arithmetic is unsigned modulo 2^W.
  - No overflow flag.
  - SUB is implemented as A + ~B + 1.
- Sampling: operands are sampled only at accept; op_a/op_b/op changes during RUN have no effect.

Test Plan:
- Bench setup: NIBBLES=4, with the ULA instance or a behavioural 4-bit model on ula_* ports.
- ADD 0x1234 + 0x0FCF, cin=0 -> result 0x2203, carry_out 0, zero 0; busy high 4 cycles; done on 5th cycle after the start edge.
- ADD 0xFFFF + 0x0000, cin=1 -> result 0x0000, carry_out 1, zero 1; per-cycle ula_cin sequence 1,1,1,1.
- SUB 0x1000 - 0x0001 -> 0x0FFF, carry_out 1; then SUB 0x0001 - 0x0002 -> 0xFFFF, carry_out 0. In both, ula_sel=100 and the first nibble has ula_b = ~B[3:0] with ula_cin=1.
- Logic ops:
  - NAND 0xF0F0, 0xFF00 -> 0x0FFF, carry_out 0.
  - NOT A 0x00FF -> 0xFF00.
  - op 111 with 0xAAAA, 0x5555 -> 0x0000, zero 1.
- Handshake:
  - start pulsed during RUN -> ignored, single done.
  - start held in the DONE cycle -> second op accepted; busy rises the next cycle with no IDLE gap.
- rst asserted asynchronously mid-cycle during RUN k=2 -> immediately busy 0, result 0, ula_* 0; no done afterwards; next start works normally.
